// File: rtl/lsu_pkg.sv
// lsu_pkg: shared constants and types for the load/store unit.
//   - MEM_WIDTH_* : width codes driven by the decoder.
//   - lsu_state_t : sequencer states.
//   - STRB_*      : byte-lane strobe patterns.
package lsu_pkg;

    localparam logic [3:0] MEM_WIDTH_WORD = 4'b0000;
    localparam logic [3:0] MEM_WIDTH_HALF = 4'b0101;
    localparam logic [3:0] MEM_WIDTH_BYTE = 4'b1010;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } lsu_state_t;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE0   = 4'b0001;
    localparam logic [3:0] STRB_LO_HALF = 4'b0011;
    localparam logic [3:0] STRB_HI_HALF = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    function automatic logic width_legal(input logic [3:0] w);
        return (w == MEM_WIDTH_WORD) || (w == MEM_WIDTH_HALF) || (w == MEM_WIDTH_BYTE);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational byte-lane steering.
//   Store side: i_st_addr_lo/i_st_width/i_st_data -> o_st_strb, o_st_data
//               (strobe for the addressed lanes, data replicated across lanes).
//   Load side:  i_ld_addr_lo/i_ld_width/i_ld_zext/i_ld_rdata -> o_ld_data
//               (addressed bytes shifted to bit 0, then sign/zero extended).
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_addr_lo,
    input  logic [3:0]  i_st_width,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_st_strb,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_addr_lo,
    input  logic [3:0]  i_ld_width,
    input  logic        i_ld_zext,
    input  logic [31:0] i_ld_rdata,
    output logic [31:0] o_ld_data
);

    logic [31:0] w_shifted;

    always_comb begin
        o_st_strb = STRB_WORD;
        o_st_data = i_st_data;
        case (i_st_width)
            MEM_WIDTH_HALF: begin
                o_st_strb = i_st_addr_lo[1] ? STRB_HI_HALF : STRB_LO_HALF;
                o_st_data = {2{i_st_data[15:0]}};
            end
            MEM_WIDTH_BYTE: begin
                o_st_strb = STRB_BYTE0 << i_st_addr_lo;
                o_st_data = {4{i_st_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_shifted = i_ld_rdata >> {i_ld_addr_lo, 3'b000};

    always_comb begin
        o_ld_data = w_shifted;
        case (i_ld_width)
            MEM_WIDTH_HALF: o_ld_data = {{16{~i_ld_zext & w_shifted[15]}}, w_shifted[15:0]};
            MEM_WIDTH_BYTE: o_ld_data = {{24{~i_ld_zext & w_shifted[7]}},  w_shifted[7:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: turns one load/store per start pulse into a single
// outstanding req/ack transfer on a word-addressed 32-bit data bus.
//   Request : start_in, mem_read_in, mem_write_in, mem_width_in,
//             mem_zero_extend_in, addr_in, wdata_in, flush_in
//   Bus     : bus_req_out, bus_we_out, bus_addr_out, bus_wstrb_out,
//             bus_wdata_out, bus_ack_in, bus_err_in, bus_rdata_in
//   Result  : stall_out, done_out, rdata_out, misaligned_out, fault_out
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [3:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        flush_in,
    output logic        bus_req_out,
    output logic        bus_we_out,
    output logic [31:0] bus_addr_out,
    output logic [3:0]  bus_wstrb_out,
    output logic [31:0] bus_wdata_out,
    input  logic        bus_ack_in,
    input  logic        bus_err_in,
    input  logic [31:0] bus_rdata_in,
    output logic        stall_out,
    output logic        done_out,
    output logic [31:0] rdata_out,
    output logic        misaligned_out,
    output logic        fault_out
);

    localparam logic TMO_EN = (TIMEOUT_CYCLES != 0);
    // Counter holds the number of ACCESS cycles already spent without ack,
    // so expiry is detected while the last allowed cycle is in progress.
    localparam logic [TIMEOUT_WIDTH-1:0] TMO_LAST =
        TIMEOUT_WIDTH'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

    lsu_state_t                r_state, w_state_nxt;
    logic                      r_req, w_req_nxt;
    logic                      r_we;
    logic [31:0]               r_bus_addr;
    logic [3:0]                r_wstrb;
    logic [31:0]               r_wdata;
    logic [3:0]                r_width;
    logic                      r_zext;
    logic [1:0]                r_addr_lo;
    logic [TIMEOUT_WIDTH-1:0]  r_tmo, w_tmo_nxt;
    logic                      r_flush, w_flush_nxt;
    logic                      r_done, w_done_nxt;
    logic                      r_mis, w_mis_nxt;
    logic                      r_fault, w_fault_nxt;
    logic [31:0]               r_rdata, w_rdata_nxt;
    logic                      w_latch;
    logic                      w_illegal, w_misaligned, w_tmo_hit;
    logic [3:0]                w_st_strb;
    logic [31:0]               w_st_data, w_ld_data;

    lsu_lane_align u_align (
        .i_st_addr_lo (addr_in[1:0]),
        .i_st_width   (mem_width_in),
        .i_st_data    (wdata_in),
        .o_st_strb    (w_st_strb),
        .o_st_data    (w_st_data),
        .i_ld_addr_lo (r_addr_lo),
        .i_ld_width   (r_width),
        .i_ld_zext    (r_zext),
        .i_ld_rdata   (bus_rdata_in),
        .o_ld_data    (w_ld_data)
    );

    assign w_illegal    = (mem_read_in == mem_write_in) || !width_legal(mem_width_in);
    assign w_misaligned = ((mem_width_in == MEM_WIDTH_HALF) && addr_in[0]) ||
                          ((mem_width_in == MEM_WIDTH_WORD) && (addr_in[1:0] != 2'b00));
    assign w_tmo_hit    = TMO_EN && (r_tmo == TMO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_tmo_nxt   = r_tmo;
        w_flush_nxt = r_flush;
        w_done_nxt  = 1'b0;
        w_mis_nxt   = 1'b0;
        w_fault_nxt = 1'b0;
        w_rdata_nxt = 32'd0;
        w_latch     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_in) begin
                    w_latch     = 1'b1;
                    w_tmo_nxt   = '0;
                    w_flush_nxt = 1'b0;
                    if (w_illegal) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_fault_nxt = 1'b1;
                    end else if (w_misaligned) begin
                        w_state_nxt = DONE;
                        w_done_nxt  = 1'b1;
                        w_mis_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ACCESS;
                        w_req_nxt   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                if (flush_in) w_flush_nxt = 1'b1;
                // Ack has priority over a timeout expiring in the same cycle.
                if (bus_ack_in) begin
                    w_state_nxt = DONE;
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = bus_err_in;
                    w_rdata_nxt = (!r_we && !bus_err_in) ? w_ld_data : 32'd0;
                end else if (w_tmo_hit) begin
                    w_state_nxt = DONE;
                    w_req_nxt   = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_fault_nxt = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TIMEOUT_WIDTH'(1);
                end
                // A flushed access still completes on the bus but reports nothing.
                if (flush_in || r_flush) begin
                    w_done_nxt  = 1'b0;
                    w_fault_nxt = 1'b0;
                    w_rdata_nxt = 32'd0;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_flush_nxt = 1'b0;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_bus_addr <= 32'd0;
            r_wstrb    <= STRB_NONE;
            r_wdata    <= 32'd0;
            r_width    <= MEM_WIDTH_WORD;
            r_zext     <= 1'b0;
            r_addr_lo  <= 2'b00;
            r_tmo      <= '0;
            r_flush    <= 1'b0;
            r_done     <= 1'b0;
            r_mis      <= 1'b0;
            r_fault    <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_tmo   <= w_tmo_nxt;
            r_flush <= w_flush_nxt;
            r_done  <= w_done_nxt;
            r_mis   <= w_mis_nxt;
            r_fault <= w_fault_nxt;
            r_rdata <= w_rdata_nxt;
            if (w_latch) begin
                r_we       <= mem_write_in;
                r_bus_addr <= {addr_in[31:2], 2'b00};
                r_wstrb    <= mem_write_in ? w_st_strb : STRB_NONE;
                r_wdata    <= w_st_data;
                r_width    <= mem_width_in;
                r_zext     <= mem_zero_extend_in;
                r_addr_lo  <= addr_in[1:0];
            end
        end
    end

    assign bus_req_out    = r_req;
    assign bus_we_out     = r_we;
    assign bus_addr_out   = r_bus_addr;
    assign bus_wstrb_out  = r_wstrb;
    assign bus_wdata_out  = r_wdata;
    assign done_out       = r_done;
    assign misaligned_out = r_mis;
    assign fault_out      = r_fault;
    assign rdata_out      = r_rdata;
    assign stall_out      = (r_state == ACCESS) || ((r_state == IDLE) && start_in);

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Sequences data-memory accesses requested by the decoded mem_read/mem_write/mem_width/mem_zero_extend controls. It converts one load/store per start pulse into a single-outstanding req/ack transaction on a 32-bit word-addressed data bus, generating byte strobes and lane-replicated write data. It aligns and extends load data, stalls the pipeline while busy, and reports misalignment, illegal controls, bus errors and timeouts. It sits between the execute stage (address from the ALU) and the data bus.

Parameters:
TIMEOUT_CYCLES, 255, cycles in ACCESS without ack before abort; 0 disables the timeout.
TIMEOUT_WIDTH, 8, width of the timeout counter; must satisfy TIMEOUT_CYCLES < 2**TIMEOUT_WIDTH.

Ports:
clk  in  1  clock; the only clock.
reset  in  1  synchronous, active-high reset.
start_in  in  1  one-cycle request from execute; sampled only in IDLE.
mem_read_in  in  1  load request.
mem_write_in  in  1  store request.
mem_width_in  in  4  0000 word, 0101 half, 1010 byte; other values are illegal.
mem_zero_extend_in  in  1  1 = zero-extend loads, 0 = sign-extend; ignored for words and stores.
addr_in  in  32  byte address.
wdata_in  in  32  store data (rs2).
flush_in  in  1  discard the result of the current access.
bus_req_out  out  1  bus request.
bus_we_out  out  1  1 = write.
bus_addr_out  out  32  {addr[31:2], 2'b00}.
bus_wstrb_out  out  4  byte-lane enables; 0000 on reads.
bus_wdata_out  out  32  lane-replicated store data.
bus_ack_in  in  1  transfer complete.
bus_err_in  in  1  error; qualified by bus_ack_in.
bus_rdata_in  in  32  read data; valid with bus_ack_in.
stall_out  out  1  holds the pipeline.
done_out  out  1  one-cycle completion pulse.
rdata_out  out  32  aligned, extended load result; 0 for stores and faults.
misaligned_out  out  1  valid with done_out.
fault_out  out  1  illegal control, bus error or timeout; valid with done_out.

Behaviour:
- Reset: state = IDLE. bus_req_out, bus_we_out, bus_wstrb_out, done_out, misaligned_out, fault_out, stall_out = 0. bus_addr_out, bus_wdata_out, rdata_out = 0. Timeout counter = 0. A reset asserted mid-ACCESS drops bus_req_out on the next edge, and any later ack is ignored.
- The states are IDLE, ACCESS and DONE. All request fields are registered at start.
- IDLE + start_in:
  - If mem_read_in == mem_write_in, or the width code is illegal, go to DONE with fault_out = 1 and no bus access.
  - If the access is misaligned (half with addr[0] = 1, or word with addr[1:0] != 0), go to DONE with misaligned_out = 1 and no bus access.
  - Otherwise go to ACCESS with bus_req_out = 1 on the next cycle.
- ACCESS: bus_req, addr, we, wstrb and wdata stay stable until ack.
  - On bus_ack_in, drop req, capture the result (fault_out = bus_err_in) and go to DONE.
  - The timeout counter increments each ACCESS cycle without ack. When it reaches TIMEOUT_CYCLES, drop req and go to DONE with fault_out = 1.
- DONE: done_out = 1 for exactly one cycle, then IDLE. The DONE→IDLE transition is unconditional.
- stall_out = 1 in ACCESS, and in IDLE when start_in is high; 0 in DONE. The pipeline advances in the DONE cycle.
- Latency: start at cycle T, req visible at T+1. Zero-wait ack at T+1 gives done_out at T+2. Error paths give done_out at T+1.
- start_in outside IDLE is ignored; the bench flags it as a protocol violation.
- flush_in in ACCESS: the access is not aborted, because a bus transaction is outstanding. A sticky flush flag is set, and the following DONE cycle has done_out = 0 with results cleared. flush_in in IDLE or DONE has no effect.
- Byte lanes:
  - Byte: strobe = 0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - Half: strobe = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - Word: strobe = 1111; wdata unchanged.
- Load alignment: rdata_out = (bus_rdata_in >> 8*addr[1:0]), truncated to the width. It is then sign- or zero-extended per the registered zero-extend bit; words pass through.
- A simultaneous ack and timeout expiry in the same cycle is treated as an ack.

Decomposition:
- lsu_pkg holds:
  - the MEM_WIDTH_WORD/HALF/BYTE constants (shared with the decoder);
  - the lsu_state_t enum {IDLE, ACCESS, DONE};
  - the lane strobe constants.
- Sub-module lsu_lane_align (combinational) computes the store strobe/data and the load extraction/extension. The FSM, registers and timeout live in load_store_unit.

Test Plan:
- SW addr 0x100, wdata 0xDEADBEEF, ack one cycle after req -> bus_addr 0x100, wstrb 1111, we 1, done_out 2 cycles after start, fault 0.
- SB addr 0x203, wdata 0x000000A5 -> bus_addr 0x200, wstrb 1000, wdata 0xA5A5A5A5.
- LB addr 0x102 then LBU addr 0x102, bus_rdata 0x1280FF34 -> rdata_out 0xFFFFFF80 (LB), 0x00000080 (LBU). LHU addr 0x102 -> 0x00001280.
- LH addr 0x101 -> no bus_req, done_out at T+1 with misaligned_out 1. Width code 0011 -> fault_out 1, no bus_req.
- TIMEOUT_CYCLES = 4, no ack -> req drops after 4 ACCESS cycles, done_out with fault_out 1. Ack with bus_err 1 -> fault_out 1, rdata_out 0.
- flush_in during ACCESS, ack 3 cycles later -> req held until ack, then no done_out. Reset during ACCESS -> req 0 next cycle, later ack ignored, state IDLE.
